// File: rtl/dsp48a1_slice_if.sv
// Operand, control and result bundle for the DSP48A1-style slice.
// Clock and the per-stage resets stay as plain ports on the slice.
interface dsp48a1_slice_if;
    logic        CEA, CEB, CEC, CED, CEM, CEP, CECARRYIN, CEOPMODE;
    logic [17:0] A, B, D, BCIN;
    logic [47:0] C, PCIN;
    logic        CARRYIN;
    logic [7:0]  OPMODE;
    logic [17:0] BCOUT;
    logic [35:0] M;
    logic [47:0] P, PCOUT;
    logic        CARRYOUT, CARRYOUTF;

    modport slave (
        input  CEA, CEB, CEC, CED, CEM, CEP, CECARRYIN, CEOPMODE,
        input  A, B, D, C, BCIN, PCIN, CARRYIN, OPMODE,
        output BCOUT, M, P, PCOUT, CARRYOUT, CARRYOUTF
    );

    modport master (
        output CEA, CEB, CEC, CED, CEM, CEP, CECARRYIN, CEOPMODE,
        output A, B, D, C, BCIN, PCIN, CARRYIN, OPMODE,
        input  BCOUT, M, P, PCOUT, CARRYOUT, CARRYOUTF
    );
endinterface

// File: rtl/dsp48a1_slice.sv
// DSP48A1-style slice: pre-adder, 18x18 unsigned multiplier, 48-bit post-adder/accumulator.
// Every pipeline stage is an optional flop with its own enable and synchronous reset.
module dsp48a1_stage #(
    parameter int W  = 18,
    parameter int EN = 1
) (
    input  logic         clk,
    input  logic         rst_i,
    input  logic         ce_i,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);
    generate
        if (EN != 0) begin : g_reg
            logic [W-1:0] q_q;
            always_ff @(posedge clk) begin
                if (rst_i)
                    q_q <= '0;
                else if (ce_i)
                    q_q <= d_i;
            end
            assign q_o = q_q;
        end else begin : g_pass
            assign q_o = d_i;
        end
    endgenerate
endmodule

module dsp48a1_slice #(
    parameter int    A0REG       = 0,
    parameter int    A1REG       = 1,
    parameter int    B0REG       = 0,
    parameter int    B1REG       = 1,
    parameter int    CREG        = 1,
    parameter int    DREG        = 1,
    parameter int    MREG        = 1,
    parameter int    PREG        = 1,
    parameter int    CARRYINREG  = 1,
    parameter int    CARRYOUTREG = 1,
    parameter int    OPMODEREG   = 1,
    parameter string CARRYINSEL  = "OPMODE5",
    parameter string B_INPUT     = "DIRECT"
) (
    input  logic             clk,
    input  logic             RSTA,
    input  logic             RSTB,
    input  logic             RSTC,
    input  logic             RSTD,
    input  logic             RSTM,
    input  logic             RSTP,
    input  logic             RSTCARRYIN,
    input  logic             RSTOPMODE,
    dsp48a1_slice_if.slave   bus
);
    localparam bit B_CASCADE  = (B_INPUT == "CASCADE");
    localparam bit CIN_FROM_PORT = (CARRYINSEL == "CARRYIN");

    logic [7:0]  opmode_r;
    logic [17:0] a0_r, a1_r, b0_in, b0_r, b1_in, b1_r, d_r, preadd;
    logic [47:0] c_r, p_r, x_mux, z_mux;
    logic [35:0] mult, m_r;
    logic        cin_src, cin_r, co_r;
    logic [48:0] post;

    dsp48a1_stage #(.W(8),  .EN(OPMODEREG)) u_opmode (.clk(clk), .rst_i(RSTOPMODE), .ce_i(bus.CEOPMODE), .d_i(bus.OPMODE), .q_o(opmode_r));
    dsp48a1_stage #(.W(18), .EN(A0REG))     u_a0     (.clk(clk), .rst_i(RSTA), .ce_i(bus.CEA), .d_i(bus.A), .q_o(a0_r));
    dsp48a1_stage #(.W(18), .EN(A1REG))     u_a1     (.clk(clk), .rst_i(RSTA), .ce_i(bus.CEA), .d_i(a0_r),  .q_o(a1_r));
    dsp48a1_stage #(.W(18), .EN(DREG))      u_d      (.clk(clk), .rst_i(RSTD), .ce_i(bus.CED), .d_i(bus.D), .q_o(d_r));
    dsp48a1_stage #(.W(48), .EN(CREG))      u_c      (.clk(clk), .rst_i(RSTC), .ce_i(bus.CEC), .d_i(bus.C), .q_o(c_r));

    assign b0_in = B_CASCADE ? bus.BCIN : bus.B;
    dsp48a1_stage #(.W(18), .EN(B0REG))     u_b0     (.clk(clk), .rst_i(RSTB), .ce_i(bus.CEB), .d_i(b0_in), .q_o(b0_r));

    // Pre-adder result optionally replaces B0 ahead of the multiplier.
    assign preadd = opmode_r[6] ? (d_r - b0_r) : (d_r + b0_r);
    assign b1_in  = opmode_r[4] ? preadd : b0_r;
    dsp48a1_stage #(.W(18), .EN(B1REG))     u_b1     (.clk(clk), .rst_i(RSTB), .ce_i(bus.CEB), .d_i(b1_in), .q_o(b1_r));

    assign mult = 36'(b1_r) * 36'(a1_r);
    dsp48a1_stage #(.W(36), .EN(MREG))      u_m      (.clk(clk), .rst_i(RSTM), .ce_i(bus.CEM), .d_i(mult), .q_o(m_r));

    assign cin_src = CIN_FROM_PORT ? bus.CARRYIN : opmode_r[5];
    dsp48a1_stage #(.W(1),  .EN(CARRYINREG)) u_cin   (.clk(clk), .rst_i(RSTCARRYIN), .ce_i(bus.CECARRYIN), .d_i(cin_src), .q_o(cin_r));

    always_comb begin
        x_mux = '0;
        unique case (opmode_r[1:0])
            2'b00: x_mux = '0;
            2'b01: x_mux = {12'd0, m_r};
            2'b10: x_mux = p_r;
            2'b11: x_mux = {d_r[11:0], a1_r, b1_r};
        endcase
    end

    always_comb begin
        z_mux = '0;
        unique case (opmode_r[3:2])
            2'b00: z_mux = '0;
            2'b01: z_mux = bus.PCIN;
            2'b10: z_mux = p_r;
            2'b11: z_mux = c_r;
        endcase
    end

    // Bit 48 is carry on add and borrow on subtract.
    assign post = opmode_r[7] ? ({1'b0, z_mux} - ({1'b0, x_mux} + 49'(cin_r)))
                              : ({1'b0, z_mux} + {1'b0, x_mux} + 49'(cin_r));

    dsp48a1_stage #(.W(48), .EN(PREG))        u_p  (.clk(clk), .rst_i(RSTP), .ce_i(bus.CEP), .d_i(post[47:0]), .q_o(p_r));
    dsp48a1_stage #(.W(1),  .EN(CARRYOUTREG)) u_co (.clk(clk), .rst_i(RSTP), .ce_i(bus.CEP), .d_i(post[48]),   .q_o(co_r));

    assign bus.BCOUT     = b1_r;
    assign bus.M         = m_r;
    assign bus.P         = p_r;
    assign bus.PCOUT     = p_r;
    assign bus.CARRYOUT  = co_r;
    assign bus.CARRYOUTF = co_r;
endmodule

// File: tb/tb_dsp48a1_slice.sv
// Directed-vector bench for dsp48a1_slice with hand-computed expected results.
module tb_dsp48a1_slice;
    logic clk = 1'b0;
    logic RSTA, RSTB, RSTC, RSTD, RSTM, RSTP, RSTCARRYIN, RSTOPMODE;
    int vectors = 0;
    int miscompares = 0;

    dsp48a1_slice_if bus ();

    dsp48a1_slice dut (
        .clk(clk),
        .RSTA(RSTA), .RSTB(RSTB), .RSTC(RSTC), .RSTD(RSTD),
        .RSTM(RSTM), .RSTP(RSTP), .RSTCARRYIN(RSTCARRYIN), .RSTOPMODE(RSTOPMODE),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [47:0] got, input logic [47:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%h, expected 0x%h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_resets(input logic v);
        RSTA = v; RSTB = v; RSTC = v; RSTD = v;
        RSTM = v; RSTP = v; RSTCARRYIN = v; RSTOPMODE = v;
    endtask

    task automatic set_ces(input logic [7:0] v);
        {bus.CEA, bus.CEB, bus.CEC, bus.CED, bus.CEM, bus.CEP, bus.CECARRYIN, bus.CEOPMODE} = v;
    endtask

    task automatic check_all(input string tag, input logic [17:0] bcout, input logic [35:0] m,
                             input logic [47:0] p, input logic co);
        check({tag, ".BCOUT"},     48'(bus.BCOUT),     48'(bcout));
        check({tag, ".M"},         48'(bus.M),         48'(m));
        check({tag, ".P"},         bus.P,              p);
        check({tag, ".PCOUT"},     bus.PCOUT,          p);
        check({tag, ".CARRYOUT"},  48'(bus.CARRYOUT),  48'(co));
        check({tag, ".CARRYOUTF"}, 48'(bus.CARRYOUTF), 48'(co));
        $display("%s: opmode=%b BCOUT=0x%h M=0x%h P=0x%h CO=%b", tag, bus.OPMODE,
                 bus.BCOUT, bus.M, bus.P, bus.CARRYOUT);
    endtask

    initial begin
        // All resets with arbitrary data, enables and opmode
        set_resets(1'b1);
        set_ces(8'($urandom));
        bus.A = 18'($urandom); bus.B = 18'($urandom); bus.D = 18'($urandom);
        bus.C = {16'($urandom), 32'($urandom)};
        bus.BCIN = 18'($urandom); bus.PCIN = {16'($urandom), 32'($urandom)};
        bus.CARRYIN = 1'($urandom); bus.OPMODE = 8'($urandom);
        tick(1);
        check_all("reset", 18'h0, 36'h0, 48'h0, 1'b0);

        // Pre-subtract, multiply, C minus M
        set_resets(1'b0);
        set_ces(8'hFF);
        bus.A = 18'd20; bus.B = 18'd10; bus.C = 48'd350; bus.D = 18'd25;
        bus.BCIN = 18'd0; bus.PCIN = 48'd0; bus.CARRYIN = 1'b0;
        bus.OPMODE = 8'b11011101;
        tick(5);
        check_all("presub", 18'hF, 36'h12C, 48'h32, 1'b0);

        // Pre-add into multiplier, post-adder outputs zero
        bus.OPMODE = 8'b00010000;
        tick(4);
        check_all("preadd", 18'h23, 36'h2BC, 48'h0, 1'b0);

        // Accumulate P onto itself from zero
        bus.OPMODE = 8'b00001010;
        tick(4);
        check_all("accum", 18'hA, 36'hC8, 48'h0, 1'b0);

        // PCIN minus concatenated operand with carry-in, borrow out
        bus.A = 18'd5; bus.B = 18'd6; bus.C = 48'd350; bus.D = 18'd25; bus.PCIN = 48'd3000;
        bus.OPMODE = 8'b10100111;
        tick(5);
        check_all("concat_sub", 18'h6, 36'h1E, 48'hFE6FFFEC0BB1, 1'b1);

        // RSTP alone clears P/CARRYOUT while B and M stages keep moving
        RSTP = 1'b1; bus.B = 18'd7;
        tick(1);
        check_all("rstp_1", 18'h7, 36'h1E, 48'h0, 1'b0);
        tick(1);
        check_all("rstp_2", 18'h7, 36'h23, 48'h0, 1'b0);
        RSTP = 1'b0;
        tick(1);
        check_all("rstp_rel", 18'h7, 36'h23, 48'hFE6FFFEC0BB0, 1'b1);

        // Pre-subtract wraps to all ones; C plus M overflows with carry out
        bus.A = 18'd1; bus.B = 18'd1; bus.D = 18'd0; bus.C = 48'hFFFF_FFFF_FFFF;
        bus.OPMODE = 8'b01011101;
        tick(5);
        check_all("wrap", 18'h3FFFF, 36'h3FFFF, 48'h3FFFE, 1'b1);

        // CEP low holds P and CARRYOUT while upstream stages change
        bus.CEP = 1'b0; bus.C = 48'd0; bus.B = 18'd2;
        tick(4);
        check_all("hold", 18'h3FFFE, 36'h3FFFE, 48'h3FFFE, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
